penalty_match_ctl: RTL and testbench
====================================

Name: penalty_match_ctl

Overview:
Parametrised match controller for the penalty game: a generalised successor to the single-shot state selection in the game top level. It sequences an N-round shootout with alternating player/CPU shooter roles, per-side scoring and sudden death, and frame-based result and shot timeouts. Outputs drive screen selection, glove/ball drawing and text overlay. It sits between mouse/shot-detection logic and the screen selector, in the VGA pixel clock domain.

Parameters:
ROUNDS, 5, regulation kick pairs (1..15)
SCORE_W, 4, score counter width (saturating)
RESULT_FRAMES, 120, frames the RESULT state is held
SHOT_TIMEOUT_FRAMES, 300, frames allowed per kick before forced miss

Ports:
clk  in  1  pixel clock
rst  in  1  asynchronous reset, active-high
frame_tick  in  1  one-cycle pulse per frame (vsync start)
start  in  1  one-cycle pulse (left click on menu/end screen)
shot_valid  in  1  kick outcome available (one-cycle pulse)
shot_goal  in  1  outcome, sampled with shot_valid: 1 = goal
shot_ready  out  1  controller accepting a kick
state  out  3  match_pkg::match_state_t
shooter  out  1  0 = player shoots, 1 = CPU shoots (player keeps)
round_num  out  8  current round, 1-based, saturates at 255
score_player  out  SCORE_W  player goals
score_cpu  out  SCORE_W  CPU goals
sudden_death  out  1  round_num > ROUNDS
match_over  out  1  high in M_END
winner  out  2  0 none, 1 player, 2 CPU

Behaviour:
- Async rst: state=M_IDLE, all outputs 0, timers cleared. Reset mid-match aborts immediately, no residue.
- All outputs registered; every change visible the cycle after its cause.
- M_IDLE: start -> M_SHOOT; scores=0, round_num=1, shooter=0.
- M_SHOOT: shot_ready=1. Handshake: kick accepted on a cycle with shot_valid && shot_ready. shot_ready drops the next cycle. On accept with shot_goal=1, increment the shooter's side score (shooter 0 -> player, 1 -> CPU). Scores saturate at 2^SCORE_W-1. Timer loads RESULT_FRAMES, then -> M_RESULT.
- Shot timeout: frame_tick counts in M_SHOOT. On reaching SHOT_TIMEOUT_FRAMES, treat as accepted miss and -> M_RESULT. If shot_valid and the timeout occur in the same cycle, shot_valid wins.
- M_RESULT: decrement on frame_tick; at 0 -> M_CHECK. shot_valid is ignored here.
- M_CHECK (exactly 1 cycle):
  - If shooter=1 (pair complete) and round_num>=ROUNDS and scores differ -> M_END.
  - Otherwise toggle shooter. If the old shooter=1, increment round_num (saturating) -> M_SHOOT.
- Sudden death: round_num>ROUNDS with tied scores. It continues pair by pair; the first unequal pair end -> M_END.
- M_END: match_over=1; winner set from the comparison and held. start -> M_IDLE, clearing scores, round and winner.
- start is ignored in M_SHOOT/M_RESULT/M_CHECK.
- frame_tick and start in the same cycle: both take effect independently.

Optional Feature:
PENALTY_EARLY_END_EN.
- Defined: M_CHECK also ends the match during regulation when the trailing side cannot catch up. Remaining kicks per side = ROUNDS - kicks taken by that side. Condition: leader_score > trailer_score + trailer_remaining.
- Undefined: regulation always plays all ROUNDS pairs.

Decomposition:
- match_pkg holds:
  - typedef enum logic[2:0] match_state_t {M_IDLE, M_SHOOT, M_RESULT, M_CHECK, M_END}
  - SHOOTER_PLAYER/SHOOTER_CPU constants
  - WIN_NONE/WIN_PLAYER/WIN_CPU constants
- One sub-module, frame_timer: load/value/frame_tick down-counter with a zero flag. It is used for both the result hold and the shot timeout.

Test Plan:
1. ROUNDS=3, RESULT_FRAMES=2. Reset mid-M_RESULT -> state=M_IDLE, scores 0, shot_ready=0 on the next edge.
2. start, then goals: player 3/3, CPU 1/3 -> M_END after round 3 pair, winner=1, score_player=3, score_cpu=1, round_num=3.
3. Tie 2-2 after 3 rounds -> sudden_death=1, round_num=4. Round 4: player goal, CPU miss -> M_END, winner=1, score 3-2.
4. No shot_valid for SHOT_TIMEOUT_FRAMES=4 frame_ticks -> miss recorded, score unchanged, M_RESULT entered. In another kick, shot_valid on the timeout cycle -> the goal counts.
5. SCORE_W=2, 5 player goals in sudden death -> score_player holds 3, no wrap.
6. PENALTY_EARLY_END_EN, ROUNDS=5: player 3 goals, CPU 0 after 3 pairs -> M_END at that M_CHECK, round_num=3. With the macro undefined, play continues to round 5.

Source files
------------

// File: rtl/match_pkg.sv
// -----------------------------------------------------------------------------
// match_pkg
// Shared types and constants for the penalty shootout match controller.
//   match_state_t : controller FSM state, also exported on the top-level port
//   SHOOTER_*     : encoding of the shooter output (who kicks this turn)
//   WIN_*         : encoding of the winner output
//   pick_winner   : score comparison helper used when the match ends
// -----------------------------------------------------------------------------
package match_pkg;

    typedef enum logic [2:0] {
        M_IDLE   = 3'd0,
        M_SHOOT  = 3'd1,
        M_RESULT = 3'd2,
        M_CHECK  = 3'd3,
        M_END    = 3'd4
    } match_state_t;

    localparam logic SHOOTER_PLAYER = 1'b0;
    localparam logic SHOOTER_CPU    = 1'b1;

    localparam logic [1:0] WIN_NONE   = 2'd0;
    localparam logic [1:0] WIN_PLAYER = 2'd1;
    localparam logic [1:0] WIN_CPU    = 2'd2;

    // Scores are zero-extended to 16 bits by the caller.
    function automatic logic [1:0] pick_winner(input logic [15:0] sp, input logic [15:0] sc);
        if (sp > sc)      return WIN_PLAYER;
        else if (sc > sp) return WIN_CPU;
        else              return WIN_NONE;
    endfunction

endpackage

// File: rtl/penalty_match_ctl_frame_timer.sv
// -----------------------------------------------------------------------------
// frame_timer
// Frame-based down-counter. A load writes load_val; otherwise each frame_tick
// decrements the count until it reaches zero, where it holds.
//   clk, rst    : pixel clock, async active-high reset (count cleared)
//   load        : load load_val this cycle (wins over frame_tick)
//   load_val    : reload value
//   frame_tick  : decrement strobe (already gated by the caller)
//   zero        : count is zero
// -----------------------------------------------------------------------------
module frame_timer #(
    parameter int W = 9
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         frame_tick,
    output logic         zero
);

    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load)
            cnt_d = load_val;
        else if (frame_tick && (cnt_q != '0))
            cnt_d = cnt_q - 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end

    assign zero = (cnt_q == '0);

endmodule

// File: rtl/penalty_match_ctl.sv
// -----------------------------------------------------------------------------
// penalty_match_ctl
// Penalty shootout sequencer: ROUNDS regulation kick pairs (player shoots,
// then CPU), then sudden death pair by pair until a pair ends unequal.
// Frame-based result hold and per-kick timeout share one frame_timer, since
// only one of them is ever running.
//
// Ports:
//   clk, rst      : pixel clock, async active-high reset
//   frame_tick    : one-cycle pulse per frame
//   start         : menu/end-screen click (honoured in M_IDLE and M_END only)
//   shot_valid    : kick outcome strobe, shot_goal sampled with it
//   shot_ready    : controller accepting a kick (M_SHOOT)
//   state         : match_state_t
//   shooter       : 0 player, 1 CPU
//   round_num     : 1-based round, saturating at 255
//   score_player, score_cpu : saturating goal counters
//   sudden_death  : round_num > ROUNDS
//   match_over    : high in M_END
//   winner        : WIN_NONE / WIN_PLAYER / WIN_CPU
// All outputs are registered.
//
// Build option: PENALTY_EARLY_END_EN ends regulation as soon as the trailing
// side can no longer catch up with its remaining kicks.
// -----------------------------------------------------------------------------
module penalty_match_ctl
    import match_pkg::*;
#(
    parameter int ROUNDS              = 5,
    parameter int SCORE_W             = 4,
    parameter int RESULT_FRAMES       = 120,
    parameter int SHOT_TIMEOUT_FRAMES = 300
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               frame_tick,
    input  logic               start,
    input  logic               shot_valid,
    input  logic               shot_goal,
    output logic               shot_ready,
    output match_state_t       state,
    output logic               shooter,
    output logic [7:0]         round_num,
    output logic [SCORE_W-1:0] score_player,
    output logic [SCORE_W-1:0] score_cpu,
    output logic               sudden_death,
    output logic               match_over,
    output logic [1:0]         winner
);

    localparam int TMAX = (RESULT_FRAMES > SHOT_TIMEOUT_FRAMES) ? RESULT_FRAMES : SHOT_TIMEOUT_FRAMES;
    localparam int TW   = $clog2(TMAX + 1);
    localparam logic [TW-1:0]      RESULT_LD = TW'(RESULT_FRAMES);
    localparam logic [TW-1:0]      SHOT_LD   = TW'(SHOT_TIMEOUT_FRAMES);
    localparam logic [SCORE_W-1:0] SCORE_MAX = '1;
    localparam logic [7:0]         ROUNDS_L  = 8'(ROUNDS);

    match_state_t       state_q, state_d;
    logic               shooter_q, shooter_d;
    logic [7:0]         round_q, round_d;
    logic [SCORE_W-1:0] sp_q, sp_d, sc_q, sc_d;
    logic [1:0]         winner_q, winner_d;
    logic               shot_ready_q, shot_ready_d;
    logic               sudden_q, sudden_d;
    logic               over_q, over_d;

    logic          tmr_load, tmr_tick, tmr_zero;
    logic [TW-1:0] tmr_val;
    logic [15:0]   sp_w, sc_w;
    logic          accept, end_reg, early, end_now;

    assign sp_w = 16'(sp_q);
    assign sc_w = 16'(sc_q);

    // shot_ready_q is only ever high in M_SHOOT, so this is the full handshake.
    assign accept = shot_valid && shot_ready_q;

    // Frames only count while a kick or a result display is in progress.
    assign tmr_tick = frame_tick && ((state_q == M_SHOOT) || (state_q == M_RESULT));

    // A completed pair at or past the last regulation round with a lead ends it;
    // in sudden death this is the first unequal pair.
    assign end_reg = (shooter_q == SHOOTER_CPU) && (round_q >= ROUNDS_L) && (sp_q != sc_q);

`ifdef PENALTY_EARLY_END_EN
    logic [7:0]  cpu_kicks;
    logic [15:0] rem_p, rem_c;
    logic        regulation;

    // In M_CHECK the player has kicked round_q times; the CPU has too only
    // once the pair is complete.
    assign regulation = (round_q <= ROUNDS_L);
    assign cpu_kicks  = (shooter_q == SHOOTER_CPU) ? round_q : 8'(round_q - 8'd1);
    assign rem_p      = 16'(8'(ROUNDS_L - round_q));
    assign rem_c      = 16'(8'(ROUNDS_L - cpu_kicks));
    assign early      = regulation && ((sp_w > sc_w + rem_c) || (sc_w > sp_w + rem_p));
`else
    assign early = 1'b0;
`endif

    assign end_now = end_reg || early;

    always_comb begin
        state_d   = state_q;
        shooter_d = shooter_q;
        round_d   = round_q;
        sp_d      = sp_q;
        sc_d      = sc_q;
        winner_d  = winner_q;
        tmr_load  = 1'b0;
        tmr_val   = SHOT_LD;

        case (state_q)
            M_IDLE: begin
                if (start) begin
                    state_d   = M_SHOOT;
                    sp_d      = '0;
                    sc_d      = '0;
                    round_d   = 8'd1;
                    shooter_d = SHOOTER_PLAYER;
                    winner_d  = WIN_NONE;
                    tmr_load  = 1'b1;
                end
            end
            M_SHOOT: begin
                // A real outcome beats a timeout landing on the same cycle.
                if (accept) begin
                    if (shot_goal) begin
                        if (shooter_q == SHOOTER_PLAYER)
                            sp_d = (sp_q == SCORE_MAX) ? sp_q : sp_q + 1'b1;
                        else
                            sc_d = (sc_q == SCORE_MAX) ? sc_q : sc_q + 1'b1;
                    end
                    state_d  = M_RESULT;
                    tmr_load = 1'b1;
                    tmr_val  = RESULT_LD;
                end else if (tmr_zero) begin
                    state_d  = M_RESULT;
                    tmr_load = 1'b1;
                    tmr_val  = RESULT_LD;
                end
            end
            M_RESULT: begin
                if (tmr_zero) state_d = M_CHECK;
            end
            M_CHECK: begin
                if (end_now) begin
                    state_d  = M_END;
                    winner_d = pick_winner(sp_w, sc_w);
                end else begin
                    state_d   = M_SHOOT;
                    shooter_d = ~shooter_q;
                    tmr_load  = 1'b1;
                    if (shooter_q == SHOOTER_CPU)
                        round_d = (round_q == 8'hFF) ? round_q : round_q + 8'd1;
                end
            end
            M_END: begin
                if (start) begin
                    state_d   = M_IDLE;
                    sp_d      = '0;
                    sc_d      = '0;
                    round_d   = '0;
                    shooter_d = SHOOTER_PLAYER;
                    winner_d  = WIN_NONE;
                end
            end
            default: state_d = M_IDLE;
        endcase

        shot_ready_d = (state_d == M_SHOOT);
        over_d       = (state_d == M_END);
        sudden_d     = (round_d > ROUNDS_L);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= M_IDLE;
            shooter_q    <= 1'b0;
            round_q      <= '0;
            sp_q         <= '0;
            sc_q         <= '0;
            winner_q     <= WIN_NONE;
            shot_ready_q <= 1'b0;
            sudden_q     <= 1'b0;
            over_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            shooter_q    <= shooter_d;
            round_q      <= round_d;
            sp_q         <= sp_d;
            sc_q         <= sc_d;
            winner_q     <= winner_d;
            shot_ready_q <= shot_ready_d;
            sudden_q     <= sudden_d;
            over_q       <= over_d;
        end
    end

    frame_timer #(.W(TW)) u_timer (
        .clk        (clk),
        .rst        (rst),
        .load       (tmr_load),
        .load_val   (tmr_val),
        .frame_tick (tmr_tick),
        .zero       (tmr_zero)
    );

    assign state        = state_q;
    assign shooter      = shooter_q;
    assign round_num    = round_q;
    assign score_player = sp_q;
    assign score_cpu    = sc_q;
    assign winner       = winner_q;
    assign shot_ready   = shot_ready_q;
    assign sudden_death = sudden_q;
    assign match_over   = over_q;

endmodule

// File: tb/tb_penalty_match_ctl.sv
// -----------------------------------------------------------------------------
// tb_penalty_match_ctl
// Directed bench for penalty_match_ctl with ROUNDS=3, SCORE_W=2,
// RESULT_FRAMES=2, SHOT_TIMEOUT_FRAMES=4. Expected scores are queued when a
// kick is driven and compared when the DUT enters M_RESULT.
// Honours PENALTY_EARLY_END_EN for the early-end expectations.
// -----------------------------------------------------------------------------
module tb_penalty_match_ctl;
    import match_pkg::*;

    localparam int ROUNDS  = 3;
    localparam int SCORE_W = 2;
    localparam logic [SCORE_W-1:0] SMAX = '1;

    logic               clk = 1'b0;
    logic               rst = 1'b0;
    logic               frame_tick = 1'b0;
    logic               start = 1'b0;
    logic               shot_valid = 1'b0;
    logic               shot_goal = 1'b0;
    logic               shot_ready;
    match_state_t       state;
    logic               shooter;
    logic [7:0]         round_num;
    logic [SCORE_W-1:0] score_player, score_cpu;
    logic               sudden_death, match_over;
    logic [1:0]         winner;

    penalty_match_ctl #(
        .ROUNDS(ROUNDS), .SCORE_W(SCORE_W), .RESULT_FRAMES(2), .SHOT_TIMEOUT_FRAMES(4)
    ) dut (
        .clk(clk), .rst(rst), .frame_tick(frame_tick), .start(start),
        .shot_valid(shot_valid), .shot_goal(shot_goal), .shot_ready(shot_ready),
        .state(state), .shooter(shooter), .round_num(round_num),
        .score_player(score_player), .score_cpu(score_cpu),
        .sudden_death(sudden_death), .match_over(match_over), .winner(winner)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [SCORE_W-1:0] sp;
        logic [SCORE_W-1:0] sc;
    } exp_t;

    exp_t sb[$];
    int checks = 0;
    int fails  = 0;

    // Bench model of the match.
    logic [SCORE_W-1:0] exp_sp, exp_sc;
    logic               exp_sh;
    logic [7:0]         exp_round;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Scoreboard: every kick enters M_RESULT with the queued scores.
    match_state_t prev_state = M_IDLE;
    always @(negedge clk) begin
        exp_t e;
        if (prev_state == M_SHOOT && state == M_RESULT) begin
            chk("sb_nonempty", 32'(sb.size() != 0), 1);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                chk("sb_player", score_player, e.sp);
                chk("sb_cpu", score_cpu, e.sc);
            end
        end
        prev_state = state;
    end

    // Advance with a frame tick every third cycle until shot_ready (or
    // match_over when want_over). st: 0 ready, 1 over, 2 budget expired.
    task automatic run_until(input bit want_over, output int st);
        st = 2;
        for (int i = 0; i < 200; i++) begin
            if (!want_over && shot_ready === 1'b1) begin st = 0; break; end
            if (match_over === 1'b1) begin st = 1; break; end
            frame_tick = (i % 3 == 2);
            @(negedge clk);
            frame_tick = 1'b0;
        end
    endtask

    // mode 0: normal kick, 1: let the shot time out, 2: shot_valid on the timeout cycle
    task automatic kick(input bit goal, input int mode);
        int st;
        run_until(1'b0, st);
        if (st == 1) return;  // match already decided
        if (st == 2) begin
            chk("kick_ready_wait", st, 0);
            return;
        end
        chk("kick_shooter", shooter, exp_sh);
        chk("kick_round", round_num, exp_round);
        if (mode != 1 && goal) begin
            if (!exp_sh) exp_sp = (exp_sp == SMAX) ? exp_sp : exp_sp + 1'b1;
            else         exp_sc = (exp_sc == SMAX) ? exp_sc : exp_sc + 1'b1;
        end
        sb.push_back('{sp: exp_sp, sc: exp_sc});
        if (mode == 0) begin
            shot_valid = 1'b1; shot_goal = goal;
            @(negedge clk);
            shot_valid = 1'b0; shot_goal = 1'b0;
            chk("ready_drop", shot_ready, 0);
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (i > 0) @(negedge clk);
                frame_tick = 1'b1;
                @(negedge clk);
                frame_tick = 1'b0;
            end
            chk("ready_before_timeout", shot_ready, 1);
            if (mode == 2) begin
                shot_valid = 1'b1; shot_goal = goal;
                @(negedge clk);
                shot_valid = 1'b0; shot_goal = 1'b0;
            end else begin
                @(negedge clk);
            end
            chk("timeout_state", state, M_RESULT);
        end
        if (exp_sh) exp_round = exp_round + 8'd1;
        exp_sh = ~exp_sh;
    endtask

    task automatic start_match();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("start_state", state, M_SHOOT);
        chk("start_round", round_num, 1);
        chk("start_scores", {score_player, score_cpu}, 0);
        chk("start_shooter", shooter, 0);
        exp_sp = '0; exp_sc = '0; exp_sh = 1'b0; exp_round = 8'd1;
    endtask

    task automatic end_match(input logic [1:0] w, input int sp, input int sc, input int rnd, input bit sd);
        int st;
        run_until(1'b1, st);
        chk("end_wait", st, 1);
        chk("end_state", state, M_END);
        chk("end_winner", winner, w);
        chk("end_player", score_player, sp);
        chk("end_cpu", score_cpu, sc);
        chk("end_round", round_num, rnd);
        chk("end_sudden", sudden_death, sd);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("idle_state", state, M_IDLE);
        chk("idle_clear", {score_player, score_cpu, round_num, winner, match_over}, 0);
    endtask

    initial begin
        int st;
        int early_round;
`ifdef PENALTY_EARLY_END_EN
        early_round = 2;
`else
        early_round = 3;
`endif
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_state", state, M_IDLE);
        chk("rst_outputs", {shot_ready, shooter, round_num, score_player, score_cpu,
                            sudden_death, match_over, winner}, 0);
        rst = 1'b0;
        @(negedge clk);

        // Match A: player 3/3, CPU 1/3.
        start_match();
        kick(1, 0); kick(0, 0);
        kick(1, 0); kick(1, 0);
        kick(1, 0); kick(0, 0);
        end_match(WIN_PLAYER, 3, 1, 3, 1'b0);

        // Match B: timeouts, 2-2 after regulation, decided in sudden death.
        start_match();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("start_ignored_shoot", state, M_SHOOT);
        kick(1, 0); kick(1, 0);
        kick(1, 1);               // timed out: miss
        kick(1, 2);               // valid on the timeout cycle: goal
        shot_valid = 1'b1; shot_goal = 1'b1;
        @(negedge clk);
        shot_valid = 1'b0; shot_goal = 1'b0;
        chk("result_ignores_shot", {score_player, score_cpu}, {exp_sp, exp_sc});
        chk("result_hold", state, M_RESULT);
        kick(1, 0); kick(0, 0);
        run_until(1'b0, st);
        chk("sd_ready", st, 0);
        chk("sd_flag", sudden_death, 1);
        chk("sd_round", round_num, 4);
        kick(1, 0); kick(0, 0);
        end_match(WIN_PLAYER, 3, 2, 4, 1'b1);

        // Match C: 2-0 after two pairs; early end only with the build option.
        start_match();
        kick(1, 0); kick(0, 0);
        kick(1, 0); kick(0, 0);
        kick(0, 0); kick(0, 0);
        end_match(WIN_PLAYER, 2, 0, early_round, 1'b0);

        // Match D: saturation in a tied sudden death, then reset mid-result.
        start_match();
        for (int i = 0; i < 6; i++) kick(0, 0);
        for (int i = 0; i < 10; i++) kick(1, 0);
        run_until(1'b0, st);
        chk("sat_ready", st, 0);
        chk("sat_player", score_player, 3);
        chk("sat_cpu", score_cpu, 3);
        chk("sat_round", round_num, 9);
        kick(1, 0);
        chk("sat_hold", score_player, 3);
        chk("pre_reset_state", state, M_RESULT);
        rst = 1'b1;
        @(negedge clk);
        chk("mid_rst_state", state, M_IDLE);
        chk("mid_rst_clear", {shot_ready, score_player, score_cpu, round_num, match_over}, 0);
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_idle", state, M_IDLE);

        chk("sb_empty", sb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired checks=%0d failures=%0d", checks, fails);
        $fatal(1, "watchdog");
    end

endmodule
